axil_mem_slave: RTL and testbench

Parametrised AXI4-Lite memory-mapped slave that succeeds the fixed 12-bit/32-bit bus definitions. Width, depth and address window are configurable. Read and write channels run as independent state machines. AW and W are accepted in any order, byte strobes are honoured, and out-of-window accesses return SLVERR. It is the slave endpoint behind the interconnect and the DUT target for the existing generator/driver/monitor/scoreboard environment.

---
 rtl/axil_mem_slave_pkg.sv | 49 ++++
 rtl/axil_mem_slave_array.sv | 41 ++++
 rtl/axil_mem_slave.sv | 187 ++++++++++++++++++
 tb/tb_axil_mem_slave.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/axil_mem_slave_pkg.sv
// rtl/axil_mem_slave_pkg.sv - shared response codes, channel structs and FSM state types for axil_mem_slave
package axil_mem_slave_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_EXOKAY = 2'b01;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

    // Channel structs sized for the widest legal configuration; narrower
    // instances use the low bits.
    localparam int AXIL_MAX_ADDR_W = 64;
    localparam int AXIL_MAX_DATA_W = 64;
    localparam int AXIL_MAX_STRB_W = AXIL_MAX_DATA_W / 8;

    typedef struct packed {
        logic [AXIL_MAX_ADDR_W-1:0] addr;
    } axil_addr_chan_t;

    typedef struct packed {
        logic [AXIL_MAX_DATA_W-1:0] data;
        logic [AXIL_MAX_STRB_W-1:0] strb;
    } axil_wdata_chan_t;

    typedef struct packed {
        resp_t resp;
    } axil_bresp_chan_t;

    typedef struct packed {
        logic [AXIL_MAX_DATA_W-1:0] data;
        resp_t                      resp;
    } axil_rdata_chan_t;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    function automatic resp_t resp_of(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/axil_mem_slave_array.sv
// rtl/axil_mem_slave_array.sv - axil_mem_array: DEPTH x DATA_WIDTH storage, byte-enable write, synchronous read
module axil_mem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int IDX_W      = 10
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    we,
    input  logic [IDX_W-1:0]        waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    re,
    input  logic [IDX_W-1:0]        raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Read samples the pre-write contents when both ports hit one word.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we) begin
                for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                    if (wstrb[b]) begin
                        mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end
            if (re) begin
                rdata <= mem[raddr];
            end
        end
    end

endmodule

// File: rtl/axil_mem_slave.sv
// rtl/axil_mem_slave.sv - AXI4-Lite memory slave; optional read output stage under AXIL_RD_PIPE_EN
module axil_mem_slave
    import axil_mem_slave_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 12,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    aclk,
    input  logic                    areset_n,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

    function automatic logic in_window(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] word;
        word = (a - BASE_ADDR) >> OFF_W;
        return (a >= BASE_ADDR) && (word < DEPTH_A);
    endfunction

    function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] word;
        word = (a - BASE_ADDR) >> OFF_W;
        return word[IDX_W-1:0];
    endfunction

    // Holds readies low until the first edge that sees reset released.
    logic live;

    wr_state_t             wr_state, wr_state_nxt;
    logic                  aw_done, w_done;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]     w_strb_q;
    resp_t                 bresp_q;
    logic                  aw_hs, w_hs, wr_fire;
    logic [ADDR_WIDTH-1:0] wr_addr_eff;
    logic [DATA_WIDTH-1:0] wr_data_eff;
    logic [STRB_W-1:0]     wr_strb_eff;

    rd_state_t             rd_state, rd_state_nxt;
    logic                  rd_err_q;
    logic                  ar_hs, ar_in_win;
    logic [DATA_WIDTH-1:0] mem_rdata, read_word;

    assign awready = live && (wr_state == W_IDLE) && !aw_done;
    assign wready  = live && (wr_state == W_IDLE) && !w_done;
    assign bvalid  = (wr_state == W_RESP);
    assign bresp   = bresp_q;

    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;

    // Either half may arrive in the same cycle as the completing one.
    assign wr_addr_eff = aw_done ? aw_addr_q : awaddr;
    assign wr_data_eff = w_done  ? w_data_q  : wdata;
    assign wr_strb_eff = w_done  ? w_strb_q  : wstrb;
    assign wr_fire     = (wr_state == W_IDLE) && (aw_done || aw_hs) && (w_done || w_hs);

    always_comb begin
        wr_state_nxt = wr_state;
        case (wr_state)
            W_IDLE:  if (wr_fire) wr_state_nxt = W_RESP;
            W_RESP:  if (bready)  wr_state_nxt = W_IDLE;
            default: wr_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            live      <= 1'b0;
            wr_state  <= W_IDLE;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            live     <= 1'b1;
            wr_state <= wr_state_nxt;
            if (wr_fire) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                bresp_q <= resp_of(!in_window(wr_addr_eff));
            end else begin
                if (aw_hs) begin
                    aw_done   <= 1'b1;
                    aw_addr_q <= awaddr;
                end
                if (w_hs) begin
                    w_done   <= 1'b1;
                    w_data_q <= wdata;
                    w_strb_q <= wstrb;
                end
            end
        end
    end

    assign arready   = live && (rd_state == R_IDLE);
    assign ar_hs     = arvalid && arready;
    assign ar_in_win = in_window(araddr);
    assign rresp     = resp_of(rd_err_q);
    assign read_word = rd_err_q ? '0 : mem_rdata;

    axil_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk    (aclk),
        .resetn (areset_n),
        .we     (wr_fire && in_window(wr_addr_eff)),
        .waddr  (word_index(wr_addr_eff)),
        .wdata  (wr_data_eff),
        .wstrb  (wr_strb_eff),
        .re     (ar_hs && ar_in_win),
        .raddr  (word_index(araddr)),
        .rdata  (mem_rdata)
    );

`ifdef AXIL_RD_PIPE_EN
    logic                  pipe_valid;
    logic [DATA_WIDTH-1:0] pipe_data;

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            pipe_valid <= 1'b0;
            pipe_data  <= '0;
        end else if ((rd_state == R_DATA) && !pipe_valid) begin
            pipe_valid <= 1'b1;
            pipe_data  <= read_word;
        end else if (rvalid && rready) begin
            pipe_valid <= 1'b0;
        end
    end

    assign rvalid = (rd_state == R_DATA) && pipe_valid;
    assign rdata  = pipe_data;
`else
    assign rvalid = (rd_state == R_DATA);
    assign rdata  = read_word;
`endif

    always_comb begin
        rd_state_nxt = rd_state;
        case (rd_state)
            R_IDLE:  if (ar_hs)            rd_state_nxt = R_DATA;
            R_DATA:  if (rvalid && rready) rd_state_nxt = R_IDLE;
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            rd_state <= R_IDLE;
            rd_err_q <= 1'b0;
        end else begin
            rd_state <= rd_state_nxt;
            if (ar_hs) begin
                rd_err_q <= !ar_in_win;
            end
        end
    end

endmodule

// File: tb/tb_axil_mem_slave.sv
// tb/tb_axil_mem_slave.sv - randomized self-checking bench for axil_mem_slave against a word-array model
module tb_axil_mem_slave;

    localparam int              AW    = 16;
    localparam int              DW    = 32;
    localparam int              DEPTH = 1024;
    localparam logic [AW-1:0]   BASE  = '0;

    logic          aclk, areset_n;
    logic [AW-1:0] awaddr, araddr;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic [DW-1:0] wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;
    logic          arvalid, arready, rvalid, rready;

    axil_mem_slave #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .aclk     (aclk),
        .areset_n (areset_n),
        .awaddr   (awaddr),
        .awvalid  (awvalid),
        .awready  (awready),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .wvalid   (wvalid),
        .wready   (wready),
        .bresp    (bresp),
        .bvalid   (bvalid),
        .bready   (bready),
        .araddr   (araddr),
        .arvalid  (arvalid),
        .arready  (arready),
        .rdata    (rdata),
        .rresp    (rresp),
        .rvalid   (rvalid),
        .rready   (rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] mdl [DEPTH];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    function automatic bit win(input logic [AW-1:0] a);
        return (int'(a) >= int'(BASE)) && ((int'(a) - int'(BASE)) / 4 < DEPTH);
    endfunction

    function automatic logic [31:0] mdl_read(input logic [AW-1:0] a);
        return win(a) ? mdl[(int'(a) - int'(BASE)) / 4] : 32'h0;
    endfunction

    task automatic mdl_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        if (win(a)) begin
            idx = (int'(a) - int'(BASE)) / 4;
            for (int b = 0; b < 4; b++)
                if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    task automatic mdl_clear();
        for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_dly);
        bit aw_ok = 0, w_ok = 0;
        int cyc = 0;
        logic [1:0] exp_resp;
        exp_resp = win(a) ? 2'b00 : 2'b10;
        awaddr = a; wdata = d; wstrb = s;
        while (!(aw_ok && w_ok) && cyc < 64) begin
            awvalid = !aw_ok && (cyc >= aw_dly);
            wvalid  = !w_ok && (cyc >= w_dly);
            @(negedge aclk);
            check("awready_idle", awready, !aw_ok);
            check("wready_idle", wready, !w_ok);
            check("bvalid_idle", bvalid, 0);
            if (awvalid && awready) aw_ok = 1;
            if (wvalid && wready) w_ok = 1;
            @(posedge aclk); #1;
            cyc++;
        end
        awvalid = 0; wvalid = 0;
        check("wr_handshake", aw_ok && w_ok, 1);
        mdl_write(a, d, s);
        bready = 0;
        for (int i = 0; i < b_dly; i++) begin
            @(negedge aclk);
            check("bvalid_hold", bvalid, 1);
            check("bresp_hold", bresp, exp_resp);
            check("aw_w_ready_resp", {awready, wready}, 0);
            @(posedge aclk); #1;
        end
        bready = 1;
        @(negedge aclk);
        check("bvalid", bvalid, 1);
        check("bresp", bresp, exp_resp);
        @(posedge aclk); #1;
        bready = 0;
        @(negedge aclk);
        check("bvalid_clear", bvalid, 0);
        @(posedge aclk); #1;
    endtask

    task automatic axi_read(input logic [AW-1:0] a, input int r_dly,
                            input logic [31:0] exp_d, input logic [1:0] exp_r);
        araddr = a; arvalid = 1;
        @(negedge aclk);
        check("arready_idle", arready, 1);
        @(posedge aclk); #1;
        arvalid = 0;
`ifdef AXIL_RD_PIPE_EN
        @(negedge aclk);
        check("rvalid_pipe_gap", rvalid, 0);
        @(posedge aclk); #1;
`endif
        @(negedge aclk);
        check("rvalid_latency", rvalid, 1);
        rready = 0;
        for (int i = 0; i < r_dly; i++) begin
            @(negedge aclk);
            check("rvalid_hold", rvalid, 1);
            check("rdata_hold", rdata, exp_d);
            check("rresp_hold", rresp, exp_r);
            check("arready_busy", arready, 0);
            @(posedge aclk); #1;
        end
        rready = 1;
        @(negedge aclk);
        check("rdata", rdata, exp_d);
        check("rresp", rresp, exp_r);
        @(posedge aclk); #1;
        rready = 0;
        @(negedge aclk);
        check("rvalid_clear", rvalid, 0);
        @(posedge aclk); #1;
    endtask

    task automatic rd_model(input logic [AW-1:0] a, input int r_dly);
        axi_read(a, r_dly, mdl_read(a), win(a) ? 2'b00 : 2'b10);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] ra;
        logic [31:0]   old_d;
        areset_n = 0; awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
        bready = 0; araddr = '0; arvalid = 0; rready = 0;
        mdl_clear();
        repeat (3) @(posedge aclk);
        #1;
        @(negedge aclk);
        check("reset_outputs", {awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata}, 0);
        @(posedge aclk); #1;
        areset_n = 1;
        @(negedge aclk);
        check("ready_before_release_edge", {awready, wready, arready}, 0);
        @(posedge aclk); #1;

        // Same-cycle AW/W, then read back
        axi_write(16'h0010, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        axi_read(16'h0010, 0, 32'hDEADBEEF, 2'b00);

        // W three cycles ahead of AW with partial strobes
        axi_write(16'h0020, 32'hAABBCCDD, 4'hF, 0, 0, 0);
        axi_write(16'h0020, 32'h11223344, 4'h5, 3, 0, 0);
        axi_read(16'h0020, 0, 32'hAA22CC44, 2'b00);

        // Window edge
        axi_write(16'h1000, 32'h12345678, 4'hF, 0, 2, 0);
        rd_model(16'h0000, 0);
        axi_read(16'h0FFC, 0, mdl_read(16'h0FFC), 2'b00);
        axi_read(16'h1004, 0, 32'h0, 2'b10);

        // Backpressure
        axi_write(16'h0040, 32'hCAFEF00D, 4'hF, 1, 0, 5);
        axi_read(16'h0040, 5, 32'hCAFEF00D, 2'b00);

        // Read and write commit on the same edge to the same word
        axi_write(16'h0030, 32'h1, 4'hF, 0, 0, 0);
        fork
            axi_write(16'h0030, 32'h2, 4'hF, 0, 0, 0);
            axi_read(16'h0030, 0, 32'h1, 2'b00);
        join
        axi_read(16'h0030, 0, 32'h2, 2'b00);

        for (int it = 0; it < 150; it++) begin
            ra = AW'($urandom_range(0, 16'h11FF));
            if ($urandom_range(0, 1) == 0)
                axi_write(ra, $urandom, 4'($urandom_range(0, 15)),
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            else
                rd_model(ra, $urandom_range(0, 3));
        end

        // Reset while a response is pending
        old_d = 32'h5A5A5A5A;
        awaddr = 16'h0050; wdata = old_d; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
        @(posedge aclk); #1;
        awvalid = 0; wvalid = 0;
        @(negedge aclk);
        check("bvalid_before_reset", bvalid, 1);
        areset_n = 0;
        @(posedge aclk); #1;
        @(negedge aclk);
        check("midreset_outputs", {awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata}, 0);
        areset_n = 1;
        mdl_clear();
        @(posedge aclk); #1;
        @(negedge aclk);
        check("ready_after_release", {awready, wready, arready}, 3'b111);
        @(posedge aclk); #1;
        axi_read(16'h0050, 0, 32'h0, 2'b00);
        rd_model(16'h0020, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
